// File: rtl/rsa_mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: p = a*b*2^-WIDTH mod m.
// Takes one multiplier bit per enabled cycle, then runs a single conditional-subtract correction.
module rsa_mont_mul #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] p
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_CORR,
        S_FIN
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_reg, b_reg, m_reg;
    logic [WIDTH+1:0] acc;
    logic [CW-1:0]    cnt;

    logic [WIDTH+1:0] b_ext, m_ext, t, u;
    logic             accept;

    // Two guard bits: acc < 2m, so t + m < 4m fits without overflow.
    assign b_ext  = {2'b00, b_reg};
    assign m_ext  = {2'b00, m_reg};
    assign t      = acc + (a_reg[cnt] ? b_ext : '0);
    assign u      = t + (t[0] ? m_ext : '0);
    assign accept = (state == S_IDLE) && start && ena;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (ena) begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of process evaluation order.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = m[0] ? S_ITER : S_FIN;
                end
            end
            S_ITER: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_next = S_CORR;
                end
            end
            S_CORR: begin
                busy       = 1'b1;
                state_next = S_FIN;
            end
            S_FIN: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand registers are reset too; they are few flops and this keeps
            // every path deterministic after reset rather than relying on X-tolerance.
            a_reg <= '0;
            b_reg <= '0;
            m_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            p     <= '0;
        end else if (ena) begin
            if (accept) begin
                a_reg <= a;
                b_reg <= b;
                m_reg <= m;
                acc   <= '0;
                cnt   <= '0;
                err   <= ~m[0];
                if (!m[0]) begin
                    p <= '0;
                end
            end else if (state == S_ITER) begin
                acc <= u >> 1;
                cnt <= cnt + 1'b1;
            end else if (state == S_CORR) begin
                p <= (acc >= m_ext) ? WIDTH'(acc - m_ext) : WIDTH'(acc);
            end
        end
    end

endmodule
